// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param_if
// Brief    : Producer/consumer bundle for the parametrised synchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              clr_err;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [c_CNT_W-1:0] count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, clr_err, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO, registered read port, programmable almost
//            thresholds, sticky overflow/underflow flags, synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  wire              clk,
    input  wire              rst,
    sync_fifo_param_if.slave bus
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // A write into a full FIFO is legal only because the same-cycle read frees a slot.
    assign w_rd_ok = bus.rd_en & ~w_empty;
    assign w_wr_ok = bus.wr_en & (~w_full | bus.rd_en);

    // Storage is not reset; the read below samples the old entry on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: a new rejection outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            if (bus.clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            if (bus.wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_CNT_W'(AF_THRESH));
    assign bus.almost_empty = (r_count <= c_CNT_W'(AE_THRESH));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Scoreboard bench for sync_fifo_param (8 bit x 16, AF=14, AE=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;
    localparam int c_DEPTH = 16;
    localparam int c_AF    = 14;
    localparam int c_AE    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(c_DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (c_DEPTH),
        .AF_THRESH(c_AF),
        .AE_THRESH(c_AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mdl_rd_data;
    bit         mdl_rd_valid;
    bit         mdl_ovf;
    bit         mdl_udf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = mdl_q.size();
        check_val("rd_valid", 32'(bus.rd_valid), 32'(mdl_rd_valid));
        check_val("rd_data", 32'(bus.rd_data), 32'(mdl_rd_data));
        check_val("count", 32'(bus.count), 32'(sz));
        check_val("full", 32'(bus.full), 32'(sz == c_DEPTH));
        check_val("empty", 32'(bus.empty), 32'(sz == 0));
        check_val("almost_full", 32'(bus.almost_full), 32'(sz >= c_AF));
        check_val("almost_empty", 32'(bus.almost_empty), 32'(sz <= c_AE));
        check_val("overflow", 32'(bus.overflow), 32'(mdl_ovf));
        check_val("underflow", 32'(bus.underflow), 32'(mdl_udf));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.wr_data  = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_q.delete();
        exp_q.delete();
        mdl_rd_data  = 8'h00;
        mdl_rd_valid = 1'b0;
        mdl_ovf      = 1'b0;
        mdl_udf      = 1'b0;
        check_all();
    endtask

    // One clock: drive, predict, then compare once the edge has settled.
    task automatic cycle(input bit wr, input logic [7:0] wd, input bit rd,
                         input bit fl = 1'b0, input bit ce = 1'b0);
        bit rd_ok;
        bit wr_ok;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        bus.flush   = fl;
        bus.clr_err = ce;
        if (fl) begin
            mdl_q.delete();
            mdl_rd_valid = 1'b0;
            if (ce) begin
                mdl_ovf = 1'b0;
                mdl_udf = 1'b0;
            end
        end else begin
            rd_ok = rd && (mdl_q.size() != 0);
            wr_ok = wr && ((mdl_q.size() != c_DEPTH) || rd);
            if (rd_ok) exp_q.push_back(mdl_q.pop_front());
            if (wr_ok) mdl_q.push_back(wd);
            if (wr && !wr_ok) mdl_ovf = 1'b1;
            else if (ce)      mdl_ovf = 1'b0;
            if (rd && !rd_ok) mdl_udf = 1'b1;
            else if (ce)      mdl_udf = 1'b0;
            mdl_rd_valid = rd_ok;
        end
        @(posedge clk);
        #1;
        if (mdl_rd_valid) begin
            if (exp_q.size() == 0) check_val("scoreboard_empty", 32'd1, 32'd0);
            else mdl_rd_data = exp_q.pop_front();
        end
        check_all();
    endtask

    initial begin
        int p_wr;
        do_reset();

        // Fill, then one rejected write.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check_val("hold_last", 32'(bus.rd_data), 32'h0F);

        // Full with simultaneous read/write, then empty with both.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        check_val("last_is_aa", 32'(bus.rd_data), 32'hAA);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Random traffic with alternating fill/drain bias for many pointer wraps.
        for (int ph = 0; ph < 6; ph++) begin
            p_wr = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 60; i++) begin
                cycle(($urandom_range(0, 99) < p_wr), 8'($urandom), ($urandom_range(0, 99) < 50),
                      1'b0, ($urandom_range(0, 7) == 0));
            end
        end

        // Flush with requests present.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check_val("after_flush", 32'(bus.rd_data), 32'h55);

        // Sticky overflow vs clear, then reset mid-operation.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i * 3), 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
        check_val("ovf_set_wins", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
